// File: rtl/counter_3to12_monitor.sv
// Passive checker for a 3..12 up/down counter with load.
// Every edge it samples the observed count and its controls and predicts the
// next value from that sample, so one bad value costs one err pulse.
// Four consecutive mismatches while locked latch a sticky FAULT state.
module counter_3to12_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] d,
  input  logic [3:0] q,
  output logic       err,
  output logic       range_err,
  output logic       wrap,
  output logic [7:0] err_cnt,
  output logic [1:0] state,
  output logic       fault
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCKED   = 2'b01,
    FAULT    = 2'b10
  } mon_state_e;

  // True when a count value lies inside the legal 3..12 window.
  function automatic logic in_range(input logic [3:0] v);
    in_range = (v >= 4'd3) && (v <= 4'd12);
  endfunction

  // Next count the counter must produce from value v under the given controls.
  // An illegal current value can only recover to 3 or to a legal load value.
  function automatic logic [3:0] contract_next(input logic [3:0] v,
                                               input logic       ud,
                                               input logic       ld,
                                               input logic [3:0] dv);
    if (ld && in_range(dv)) begin
      contract_next = dv;
    end else if (!in_range(v)) begin
      contract_next = 4'd3;
    end else if (ld) begin
      contract_next = v;
    end else if (ud) begin
      contract_next = (v == 4'd12) ? 4'd3 : v + 4'd1;
    end else begin
      contract_next = (v == 4'd3) ? 4'd12 : v - 4'd1;
    end
  endfunction

  mon_state_e state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] prev_q, prev_d;
  logic       prev_up_q, prev_up_d;
  logic       prev_load_q, prev_load_d;
  logic [2:0] consec_q, consec_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_q, err_d;
  logic       range_err_q, range_err_d;
  logic       wrap_q, wrap_d;
  logic       fault_q, fault_d;
  logic       mismatch_s;
  logic [2:0] consec_inc_s;
  logic [7:0] err_cnt_inc_s;

  // Compare the sample against the prediction and work out every next value.
  always_comb begin
    state_d       = state_q;
    consec_d      = consec_q;
    err_cnt_d     = err_cnt_q;
    err_d         = 1'b0;
    mismatch_s    = (q != exp_q) || !in_range(q);
    consec_inc_s  = (consec_q == 3'd4) ? consec_q : consec_q + 3'd1;
    err_cnt_inc_s = (err_cnt_q == 8'd255) ? err_cnt_q : err_cnt_q + 8'd1;
    exp_d         = contract_next(q, up_down, load, d);
    prev_d        = q;
    prev_up_d     = up_down;
    prev_load_d   = load;
    range_err_d   = !in_range(q);
    wrap_d        = ((prev_q == 4'd12) && (q == 4'd3)  &&  prev_up_q && !prev_load_q) ||
                    ((prev_q == 4'd3)  && (q == 4'd12) && !prev_up_q && !prev_load_q);

    case (state_q)
      UNLOCKED: begin
        consec_d = 3'd0;
        if (!mismatch_s) begin
          state_d = LOCKED;
        end else begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (mismatch_s) begin
          err_d     = 1'b1;
          err_cnt_d = err_cnt_inc_s;
          consec_d  = consec_inc_s;
          if (consec_inc_s == 3'd4) begin
            state_d = FAULT;
          end else begin
            state_d = LOCKED;
          end
        end else begin
          consec_d = 3'd0;
        end
      end
      FAULT: begin
        // Sticky: only reset leaves FAULT, but checking carries on.
        if (mismatch_s) begin
          err_d     = 1'b1;
          err_cnt_d = err_cnt_inc_s;
          consec_d  = consec_inc_s;
        end else begin
          consec_d  = 3'd0;
        end
      end
      default: begin
        state_d  = FAULT;
        consec_d = 3'd0;
      end
    endcase

    fault_d = (state_d == FAULT);
  end

  // Monitor state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      exp_q       <= 4'd3;
      prev_q      <= 4'd3;
      prev_up_q   <= 1'b1;
      prev_load_q <= 1'b0;
      consec_q    <= 3'd0;
      err_cnt_q   <= 8'd0;
      err_q       <= 1'b0;
      range_err_q <= 1'b0;
      wrap_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      prev_q      <= prev_d;
      prev_up_q   <= prev_up_d;
      prev_load_q <= prev_load_d;
      consec_q    <= consec_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      range_err_q <= range_err_d;
      wrap_q      <= wrap_d;
      fault_q     <= fault_d;
    end
  end

  assign err       = err_q;
  assign range_err = range_err_q;
  assign wrap      = wrap_q;
  assign err_cnt   = err_cnt_q;
  assign state     = state_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_counter_3to12_monitor.sv
// Directed bench for counter_3to12_monitor with hand-computed expectations.
`timescale 1ns/1ps
module tb_counter_3to12_monitor;

  logic       clk;
  logic       reset;
  logic       up_down;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic       err;
  logic       range_err;
  logic       wrap;
  logic [7:0] err_cnt;
  logic [1:0] state;
  logic       fault;

  int checks_q;
  int errors_q;
  int wrap_seen;
  int err_seen;

  counter_3to12_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .up_down   (up_down),
    .load      (load),
    .d         (d),
    .q         (q),
    .err       (err),
    .range_err (range_err),
    .wrap      (wrap),
    .err_cnt   (err_cnt),
    .state     (state),
    .fault     (fault)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks_q++;
    if (got !== want) begin
      errors_q++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Present one sample, clock it in, then settle just after the edge.
  task automatic step(input logic [3:0] qv, input logic ud, input logic ld, input logic [3:0] dv);
    q       = qv;
    up_down = ud;
    load    = ld;
    d       = dv;
    @(posedge clk);
    #1;
    if (wrap === 1'b1) wrap_seen++;
    if (err === 1'b1)  err_seen++;
  endtask

  initial begin
    checks_q  = 0;
    errors_q  = 0;
    wrap_seen = 0;
    err_seen  = 0;
    reset   = 1'b1;
    q       = 4'd15;
    up_down = 1'b0;
    load    = 1'b1;
    d       = 4'd9;
    @(posedge clk);
    #1;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_cnt", 32'(err_cnt), 32'd0);
    check_val("rst_flags", {29'd0, err, range_err, wrap}, 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;

    // Up count 3..12,3: locks on first sample, one wrap, no errors.
    step(4'd3, 1'b1, 1'b0, 4'd0);
    check_val("lock_first", 32'(state), 32'd1);
    for (int v = 4; v <= 12; v++) step(4'(v), 1'b1, 1'b0, 4'd0);
    check_val("no_wrap_yet", 32'(wrap_seen), 32'd0);
    step(4'd3, 1'b1, 1'b0, 4'd0);
    check_val("up_wrap", 32'(wrap), 32'd1);
    check_val("up_wrap_cnt", 32'(wrap_seen), 32'd1);
    check_val("up_err_cnt", 32'(err_cnt), 32'd0);

    // Down from 5 through 3 -> 12.
    wrap_seen = 0;
    step(4'd4, 1'b1, 1'b0, 4'd0);
    step(4'd5, 1'b0, 1'b0, 4'd0);
    step(4'd4, 1'b0, 1'b0, 4'd0);
    step(4'd3, 1'b0, 1'b0, 4'd0);
    step(4'd12, 1'b0, 1'b0, 4'd0);
    check_val("dn_wrap", 32'(wrap), 32'd1);
    check_val("dn_wrap_cnt", 32'(wrap_seen), 32'd1);
    check_val("dn_err_seen", 32'(err_seen), 32'd0);

    // Legal load of 7 from 4, illegal load of 14 from 9 holds.
    step(4'd11, 1'b0, 1'b1, 4'd4);
    step(4'd4, 1'b1, 1'b1, 4'd7);
    step(4'd7, 1'b1, 1'b0, 4'd0);
    check_val("load7_err", 32'(err), 32'd0);
    step(4'd8, 1'b1, 1'b0, 4'd0);
    step(4'd9, 1'b1, 1'b1, 4'd14);
    step(4'd9, 1'b1, 1'b0, 4'd0);
    check_val("load14_err", 32'(err), 32'd0);
    check_val("load_err_seen", 32'(err_seen), 32'd0);
    check_val("load_state", 32'(state), 32'd1);

    // Inject 8 where 6 is expected, then continue correctly from 8.
    step(4'd10, 1'b1, 1'b1, 4'd5);
    step(4'd5, 1'b1, 1'b0, 4'd0);
    step(4'd8, 1'b1, 1'b0, 4'd0);
    check_val("inj_err", 32'(err), 32'd1);
    check_val("inj_cnt", 32'(err_cnt), 32'd1);
    step(4'd9, 1'b1, 1'b0, 4'd0);
    check_val("resync_err", 32'(err), 32'd0);
    check_val("resync_cnt", 32'(err_cnt), 32'd1);
    check_val("resync_state", 32'(state), 32'd1);

    // Out-of-range samples: four in a row reach FAULT.
    step(4'd15, 1'b1, 1'b0, 4'd0);
    check_val("rng_err", 32'(range_err), 32'd1);
    check_val("rng_mis", 32'(err), 32'd1);
    step(4'd15, 1'b1, 1'b0, 4'd0);
    step(4'd15, 1'b1, 1'b0, 4'd0);
    check_val("third_bad", 32'(state), 32'd1);
    step(4'd15, 1'b1, 1'b0, 4'd0);
    check_val("fault_state", 32'(state), 32'd2);
    check_val("fault_pin", 32'(fault), 32'd1);
    check_val("fault_cnt", 32'(err_cnt), 32'd5);
    step(4'd3, 1'b1, 1'b0, 4'd0);
    check_val("fault_good_err", 32'(err), 32'd0);
    check_val("fault_good_rng", 32'(range_err), 32'd0);
    check_val("fault_sticky", 32'(state), 32'd2);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) step(4'd15, 1'b1, 1'b0, 4'd0);
    check_val("sat_cnt", 32'(err_cnt), 32'd255);
    check_val("sat_err", 32'(err), 32'd1);
    check_val("sat_fault", 32'(fault), 32'd1);

    // Asynchronous reset between edges while in FAULT.
    #2;
    reset = 1'b1;
    #1;
    check_val("async_state", 32'(state), 32'd0);
    check_val("async_fault", 32'(fault), 32'd0);
    check_val("async_cnt", 32'(err_cnt), 32'd0);
    check_val("async_err", 32'(err), 32'd0);
    // Held reset ignores bad samples across an edge.
    step(4'd15, 1'b0, 1'b0, 4'd0);
    check_val("hold_flags", {29'd0, err, range_err, wrap}, 32'd0);
    check_val("hold_state", 32'(state), 32'd0);
    reset = 1'b0;

    // First sample after release compared against 3: 5 mismatches silently.
    step(4'd5, 1'b1, 1'b0, 4'd0);
    check_val("first_unlocked", 32'(state), 32'd0);
    check_val("first_no_err", 32'(err), 32'd0);
    check_val("first_cnt", 32'(err_cnt), 32'd0);
    step(4'd6, 1'b1, 1'b0, 4'd0);
    check_val("relock", 32'(state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule

// File: doc/counter_3to12_monitor.md
COUNTER_3TO12_MONITOR -- requirements
Module: counter_3to12_monitor

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: up_down  input  1  counter direction control as driven to the counter (1 = up, 0 = down).
REQ-004 SHALL have port: load  input  1  counter load control as driven to the counter.
REQ-005 SHALL have port: d  input  4  counter load data as driven to the counter.
REQ-006 SHALL have port: q  input  4  observed counter output.
REQ-007 SHALL have port: err  output  1  one-cycle pulse; sampled q differed from predicted value.
REQ-008 SHALL have port: range_err  output  1  one-cycle pulse; sampled q outside 3..12.
REQ-009 SHALL have port: wrap  output  1  one-cycle pulse; legal wrap observed (12->3 counting up, 3->12 counting down).
REQ-010 SHALL have port: err_cnt  output  8  saturating count of err pulses.
REQ-011 SHALL have port: state  output  2  monitor state (00 UNLOCKED, 01 LOCKED, 10 FAULT).
REQ-012 SHALL have port: fault  output  1  high while state = FAULT.

Function
REQ-013 Counter contract SHALL be: range 3..12; reset value 3; load has priority over count; load with d in 3..12 -> q=d; load with d outside 3..12 -> q holds; up: 12->3 else +1; down: 3->12 else -1.
REQ-014 Each rising edge SHALL sample q, up_down, load, d together.
REQ-015 Prediction register exp SHALL update every edge to contract-next(sampled q, sampled controls), i.e. always resync from observed q.
REQ-016 If sampled q is outside 3..12, exp SHALL become 3, or d when load=1 and d is in 3..12.
REQ-017 mismatch SHALL be (sampled q != exp); err/range_err/wrap SHALL be registered on the same edge, so asserted in the cycle after the offending sample and low the next cycle unless re-triggered.
REQ-018 range_err SHALL pulse on every out-of-range sample in every state; an out-of-range sample also counts as a mismatch.
REQ-019 wrap SHALL pulse when the previous sample was 12, the current is 3, and the previous up_down=1 with load=0; or previous 3, current 12, previous up_down=0, load=0; wrap is independent of err.
REQ-020 UNLOCKED: match -> LOCKED; mismatch -> stay UNLOCKED, no err, no err_cnt change.
REQ-021 LOCKED: mismatch -> err pulse, err_cnt+1, consecutive-mismatch counter +1; match -> consecutive counter cleared.
REQ-022 LOCKED -> FAULT when the consecutive-mismatch counter reaches 4 (on the edge of the 4th mismatch).
REQ-023 FAULT SHALL be sticky until reset; checking, err pulses and err_cnt counting SHALL continue in FAULT.
REQ-024 err_cnt SHALL saturate at 255 and never wrap.
REQ-025 The first sample after reset release SHALL be compared against exp = 3.

Reset
REQ-026 reset=1 SHALL asynchronously force: state=UNLOCKED, exp=3, previous-sample register=3, consecutive counter=0, err_cnt=0, err=0, range_err=0, wrap=0, fault=0.
REQ-027 Reset asserted mid-operation, including in FAULT, SHALL give the same result within the same cycle, without waiting for a clock edge.
REQ-028 The module SHALL hold its reset values while reset=1, regardless of q and controls.

Verification
REQ-029 Reset, then q=3 with up_down=1, load=0 -> state 01 after the first edge; q follows 3..12,3 with up counting -> one wrap pulse on 12->3, err_cnt=0.
REQ-030 Down counting from 5 through 3->12 -> one wrap pulse, no err.
REQ-031 load=1, d=7 for one cycle from q=4 -> next q=7 accepted, no err; load=1, d=14 from q=9 -> next q=9 accepted, no err.
REQ-032 In LOCKED, inject q=8 when 6 is expected -> one err pulse, err_cnt=1; the next correct step from 8 is accepted.
REQ-033 Inject q=15 -> range_err and err pulse; 4 consecutive bad samples -> state 10, fault=1 held until reset; 300 mismatches -> err_cnt=255.
REQ-034 Assert reset asynchronously between edges while in FAULT -> fault, err_cnt and state cleared immediately.
